// File: rtl/hazard_sb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_pkg : shared encodings and defaults for the hazard unit      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package hazard_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB      = 2'b01;
  localparam logic [1:0] FWD_MEM     = 2'b10;

  localparam int DEFAULT_REG_AW   = 5;
  localparam int DEFAULT_NUM_REGS = 32;

endpackage
`default_nettype wire

// File: rtl/sb_pending.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sb_pending : pending-destination vector, in-flight counter, error   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module sb_pending
  import hazard_pkg::*;
#(
  parameter int REG_AW          = DEFAULT_REG_AW,
  parameter int NUM_REGS        = DEFAULT_NUM_REGS,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set,
  input  logic [REG_AW-1:0]   set_rd,
  input  logic                clr,
  input  logic [REG_AW-1:0]   clr_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    count,
  output logic                sb_err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:1] pend_q;
  logic [NUM_REGS-1:1] pend_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                err_q;
  logic                set_live;
  logic                cnt_zero;
  logic                cnt_full;
  logic                err_now;

  // Register 0 never holds a pending bit; it is tied low here.
  assign pending  = {pend_q, 1'b0};
  assign count    = count_q;
  assign sb_err   = err_q;

  assign set_live = set && (set_rd != '0);
  assign cnt_zero = (count_q == '0);
  assign cnt_full = (count_q == MAX_CNT);

  assign err_now = (clr && !pending[clr_rd] && (clr_rd != '0))
                 || (clr && cnt_zero)
                 || (set && !clr && cnt_full)
                 || (set_live && clr && (clr_rd == set_rd));

  // Set takes priority over a same-cycle clear of the same register.
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (set_live && (set_rd == REG_AW'(i))) begin
        pend_d[i] = 1'b1;
      end else if (clr && (clr_rd == REG_AW'(i))) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (set && !clr) begin
      count_d = cnt_full ? count_q : count_q + 1'b1;
    end else if (clr && !set) begin
      count_d = cnt_zero ? count_q : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      count_q <= count_d;
      err_q   <= err_q | err_now;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_sb : 5-stage hazard unit with long-op register scoreboard    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW          = DEFAULT_REG_AW,
  parameter int NUM_REGS        = DEFAULT_NUM_REGS,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic              long_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              result_src_e_0,
  input  logic              long_e,
  input  logic              pc_src_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              regwrite_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_w,
  input  logic              lr_done,
  input  logic [REG_AW-1:0] lr_rd,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic [1:0]        forward_operand_a_e,
  output logic [1:0]        forward_operand_b_e,
  output logic              sb_busy,
  output logic              sb_err
);

  logic [NUM_REGS-1:0] pending;
  logic [CNT_W-1:0]    count;
  logic                err_raw;
  logic                lw_stall;
  logic                le_stall;
  logic                sb_stall;
  logic                bud_stall;
  logic                stall;
  logic [CNT_W:0]      inflight;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if ((rs != '0) && regwrite_m && (rs == rd_m)) return FWD_MEM;
    if ((rs != '0) && regwrite_w && (rs == rd_w)) return FWD_WB;
    return FWD_REGFILE;
  endfunction

  sb_pending #(
    .REG_AW          (REG_AW),
    .NUM_REGS        (NUM_REGS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_sb_pending (
    .clk     (clk),
    .reset   (reset),
    .set     (long_e),
    .set_rd  (rd_e),
    .clr     (lr_done),
    .clr_rd  (lr_rd),
    .pending (pending),
    .count   (count),
    .sb_err  (err_raw)
  );

  assign lw_stall = result_src_e_0 && (rd_e != '0)
                  && ((rs1_d == rd_e) || (rs2_d == rd_e));
  assign le_stall = long_e && (rd_e != '0)
                  && ((rs1_d == rd_e) || (rs2_d == rd_e) || (rd_d == rd_e));
  assign sb_stall = pending[rs1_d] || pending[rs2_d] || pending[rd_d];

  // A long op in E this cycle already occupies a slot for the D instruction.
  assign inflight  = {1'b0, count} + (CNT_W+1)'(long_e);
  assign bud_stall = long_d && (inflight >= (CNT_W+1)'(MAX_OUTSTANDING));

  assign stall = lw_stall || le_stall || sb_stall || bud_stall;

  assign stall_f = !reset && stall && !pc_src_e;
  assign stall_d = !reset && stall && !pc_src_e;
  assign flush_d = !reset && pc_src_e;
  assign flush_e = !reset && (stall || pc_src_e);

  assign forward_operand_a_e = reset ? FWD_REGFILE : fwd_sel(rs1_e);
  assign forward_operand_b_e = reset ? FWD_REGFILE : fwd_sel(rs2_e);

  assign sb_busy = !reset && (count != '0);
  assign sb_err  = !reset && err_raw;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_sb : scenario bench for hazard_sb with expected-out queue |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_hazard_sb;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lr_rd;
  logic       long_d, result_src_e_0, long_e, pc_src_e;
  logic       regwrite_m, regwrite_w, lr_done;
  logic       stall_f, stall_d, flush_d, flush_e, sb_busy, sb_err;
  logic [1:0] forward_operand_a_e, forward_operand_b_e;

  logic [9:0] exp_q[$];
  logic [9:0] got, want;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  hazard_sb #(
    .REG_AW(5), .NUM_REGS(32), .MAX_OUTSTANDING(2), .CNT_W(3)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .rs1_d               (rs1_d),
    .rs2_d               (rs2_d),
    .rd_d                (rd_d),
    .long_d              (long_d),
    .rs1_e               (rs1_e),
    .rs2_e               (rs2_e),
    .rd_e                (rd_e),
    .result_src_e_0      (result_src_e_0),
    .long_e              (long_e),
    .pc_src_e            (pc_src_e),
    .rd_m                (rd_m),
    .regwrite_m          (regwrite_m),
    .rd_w                (rd_w),
    .regwrite_w          (regwrite_w),
    .lr_done             (lr_done),
    .lr_rd               (lr_rd),
    .stall_f             (stall_f),
    .stall_d             (stall_d),
    .flush_d             (flush_d),
    .flush_e             (flush_e),
    .forward_operand_a_e (forward_operand_a_e),
    .forward_operand_b_e (forward_operand_b_e),
    .sb_busy             (sb_busy),
    .sb_err              (sb_err)
  );

  // Expected output word: {stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, busy, err}
  function automatic logic [9:0] mk(input logic st, input logic fd, input logic fe,
                                    input logic [1:0] fa, input logic [1:0] fb,
                                    input logic busy, input logic err);
    return {st, st, fd, fe, fa, fb, busy, err};
  endfunction

  task automatic idle();
    reset = 1'b0;
    rs1_d = '0; rs2_d = '0; rd_d = '0; long_d = 1'b0;
    rs1_e = '0; rs2_e = '0; rd_e = '0; result_src_e_0 = 1'b0; long_e = 1'b0;
    pc_src_e = 1'b0; rd_m = '0; regwrite_m = 1'b0; rd_w = '0; regwrite_w = 1'b0;
    lr_done = 1'b0; lr_rd = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      nxt();
      case (i)
        0: begin reset = 1; pc_src_e = 1; rs1_e = 5; rd_m = 5; regwrite_m = 1;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        1: begin reset = 1; result_src_e_0 = 1; rd_e = 7; rs1_d = 7;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        default: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0));
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_forwarding();
    for (int i = 0; i < 5; i++) begin
      nxt();
      case (i)
        0: begin rs1_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
                 exp_q.push_back(mk(0,0,0,2'b10,2'b00,0,0)); end
        1: begin rs1_e = 0; rs2_e = 5; rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b10,0,0)); end
        2: begin rs1_e = 8; rs2_e = 8; rd_m = 8; regwrite_m = 0; rd_w = 8; regwrite_w = 1;
                 exp_q.push_back(mk(0,0,0,2'b01,2'b01,0,0)); end
        3: begin rs1_e = 12; rd_m = 12; regwrite_m = 1; rs2_e = 13; rd_w = 13; regwrite_w = 1;
                 exp_q.push_back(mk(0,0,0,2'b10,2'b01,0,0)); end
        default: begin rd_m = 0; regwrite_m = 1; rd_w = 0; regwrite_w = 1;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL forwarding[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 6; i++) begin
      nxt();
      case (i)
        0: begin result_src_e_0 = 1; rd_e = 7; rs2_d = 7;
                 exp_q.push_back(mk(1,0,1,2'b00,2'b00,0,0)); end
        1: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0));
        2: begin result_src_e_0 = 1; rd_e = 7; rs2_d = 7; pc_src_e = 1;
                 exp_q.push_back(mk(0,1,1,2'b00,2'b00,0,0)); end
        3: begin result_src_e_0 = 1; rd_e = 0; rs1_d = 0;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        4: begin result_src_e_0 = 0; rd_e = 7; rs1_d = 7;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        default: begin result_src_e_0 = 1; rd_e = 7; rs1_d = 7;
                 exp_q.push_back(mk(1,0,1,2'b00,2'b00,0,0)); end
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL load_use[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_sb_raw();
    for (int i = 0; i < 5; i++) begin
      nxt();
      case (i)
        0: begin long_e = 1; rd_e = 9; rs1_d = 9;
                 exp_q.push_back(mk(1,0,1,2'b00,2'b00,0,0)); end
        1: begin rs1_d = 9; exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        2: begin rs2_d = 9; exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        3: begin rs1_d = 9; lr_done = 1; lr_rd = 9;
                 exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        default: begin rs1_d = 9; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL sb_raw[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_budget();
    for (int i = 0; i < 7; i++) begin
      nxt();
      case (i)
        0: begin long_e = 1; rd_e = 3; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        1: begin long_e = 1; rd_e = 4; long_d = 1; rd_d = 5;
                 exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        2: begin long_d = 1; rd_d = 5; exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        3: begin long_d = 1; rd_d = 5; lr_done = 1; lr_rd = 3;
                 exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        4: begin long_d = 1; rd_d = 5; rs1_d = 3;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        5: begin lr_done = 1; lr_rd = 4; exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        default: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0));
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL budget[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_waw_x0();
    for (int i = 0; i < 7; i++) begin
      nxt();
      case (i)
        0: begin long_e = 1; rd_e = 6; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        1: begin rd_d = 6; exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        2: begin long_e = 1; rd_e = 0; rd_d = 6;
                 exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        3: begin long_d = 1; exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,0)); end
        4: begin lr_done = 1; lr_rd = 6; exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        5: begin rd_d = 6; lr_done = 1; lr_rd = 0;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        default: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0));
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL waw_x0[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 3; i++) begin
      nxt();
      case (i)
        0: begin lr_done = 1; lr_rd = 11; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        default: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,1));
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL errors[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      nxt();
      case (i)
        0: begin reset = 1; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        1: begin long_e = 1; rd_e = 3; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        2: begin long_e = 1; rd_e = 4; exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        3: begin reset = 1; pc_src_e = 1; rs1_e = 5; rd_m = 5; regwrite_m = 1; rs1_d = 3;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        4: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0));
        5: begin rs1_d = 3; lr_done = 1; lr_rd = 3;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        default: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,1));
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL reset_mid[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      nxt();
      case (i)
        0: begin reset = 1; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        1: begin long_e = 1; rd_e = 1; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        2: begin long_e = 1; rd_e = 2; exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        3: begin long_e = 1; rd_e = 13; exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        4: begin lr_done = 1; lr_rd = 1; exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,1)); end
        5: begin lr_done = 1; lr_rd = 2; exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,1)); end
        default: exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,1));
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL overflow[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  task automatic test_set_clr_same();
    for (int i = 0; i < 4; i++) begin
      nxt();
      case (i)
        0: begin reset = 1; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        1: begin long_e = 1; rd_e = 20; exp_q.push_back(mk(0,0,0,2'b00,2'b00,0,0)); end
        2: begin long_e = 1; rd_e = 20; lr_done = 1; lr_rd = 20;
                 exp_q.push_back(mk(0,0,0,2'b00,2'b00,1,0)); end
        default: begin rs1_d = 20; exp_q.push_back(mk(1,0,1,2'b00,2'b00,1,1)); end
      endcase
      @(negedge clk);
      got  = {stall_f, stall_d, flush_d, flush_e, forward_operand_a_e, forward_operand_b_e, sb_busy, sb_err};
      want = exp_q.pop_front();
      n_checks++;
      if (got !== want) begin n_fail++; $display("FAIL set_clr_same[%0d]: got %b want %b", i, got, want); end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_sb_raw();
    test_budget();
    test_waw_x0();
    test_errors();
    test_reset_mid();
    test_overflow();
    test_set_clr_same();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
